sr_frame_rx: RTL and testbench
==============================

// Module: sr_frame_rx
// PURPOSE
//   Receive-side counterpart of the LED shift-register link: samples the serial stream
//   (data, sr_clk, r_clk) on the system clock and rebuilds the parallel strand words.
//   Reassembles 24-bit GRB pixels per strand and hands them out over valid/ready.
//   Serves as the loopback checker for the LED-wall transmit path and as the input
//   stage of a daisy-chained wall tile.
// PARAMETERS
//   STRANDS      8     strands per latch word (= shift-register width)
//   BITS_PER_LED 24    bits per pixel, G[7:0],R[7:0],B[7:0], MSB first
//   LEDS         5     pixels per strand per frame
//   SYNC_STAGES  2     flops in each input synchroniser (>=2)
//   IDLE_CYCLES  1024  clk_in cycles without an sr_clk edge before the frame resyncs
// PORTS
//   clk_in      in   1               system clock; must be >= 4x sr_clk frequency
//   ar          in   1               reset, asynchronous, active-low
//   data_in     in   1               serial data, async to clk_in
//   sr_clk_in   in   1               serial shift clock, async, sampled only
//   r_clk_in    in   1               latch clock, async, sampled only
//   pix_data    out  STRANDS*24      pixel word; bits [24k+23:24k] = strand k, GRB
//   pix_idx     out  clog2(LEDS)     LED position of pix_data within the strand
//   pix_valid   out  1               pix_data/pix_idx valid
//   pix_ready   in   1               consumer accepts when pix_valid&pix_ready
//   frame_done  out  1               1-cycle pulse with last pixel (pix_idx==LEDS-1)
//   bit_err     out  1               1-cycle pulse: latch seen with shift count != STRANDS
//   overflow    out  1               sticky: a pixel was overwritten before acceptance
// BEHAVIOUR
//   Reset (ar=0): all outputs 0; shift reg, shift count, bit_pos, led counter,
//     idle counter, sync flops all 0. Takes effect immediately, even mid-frame.
//   Inputs pass through SYNC_STAGES flops each (same depth, so data stays aligned).
//     Rising edges are detected as cur&~prev on the synchronised sr_clk and r_clk.
//   sr_clk rise: shreg <= {shreg[STRANDS-2:0], data}; shift count increments,
//     saturating at STRANDS+1.
//   r_clk rise: if shift count==STRANDS, latch word = shreg (word[k] -> strand k).
//     Otherwise pulse bit_err, discard the word, and set bit_pos=0. The LED counter
//     is unchanged. Shift count clears in both cases.
//   sr_clk and r_clk rise in the same cycle: shift first, then latch evaluates the
//     post-shift register and count.
//   Accepted word at bit_pos b: acc[k][23-b] <= word[k]; bit_pos wraps 23->0.
//   On bit_pos==23: pix_data <= assembled acc (including this word), pix_idx <= led
//     counter, pix_valid <= 1. The LED counter wraps LEDS-1 -> 0. frame_done pulses in
//     the same cycle pix_valid rises when pix_idx==LEDS-1.
//   Latency: pix_valid rises 1 cycle after the synchronised r_clk edge is detected
//     (SYNC_STAGES+2 clk_in cycles after the raw r_clk rise).
//   Handshake: pix_valid stays high and pix_data holds until pix_valid&pix_ready;
//     pix_valid drops the next cycle unless a new pixel completes that cycle.
//   New pixel completes while pix_valid=1 and not accepted this cycle: set overflow
//     (cleared only by reset). The new pixel overwrites; pix_valid stays 1.
//   New pixel completes in the same cycle as acceptance: no overflow; the new pixel
//     loads and pix_valid stays 1.
//   Idle: the idle counter counts cycles with no sr_clk rise. At IDLE_CYCLES it clears
//     bit_pos, the LED counter and the shift count (frame boundary); no error flags.
//     Pending pix_valid is untouched.
// STRUCTURE
//   Shared package: localparam PIX_W=24, GRB field offsets (G=23:16, R=15:8, B=7:0),
//     and clog2 helper.
//   One sub-module, sr_edge_sync: SYNC_STAGES synchroniser plus rising-edge pulse,
//     instanced three times (data uses sync only).
//   Top holds the shift/latch logic, pixel assembler, handshake and counters.
// TESTING
//   Use sr_clk = clk_in/8 and r_clk after every 8 bits throughout.
//   1 Send a frame: strand0 = pixels 00FF00,FF0000,0000FF,00FF00,FFFFFF, others 0;
//     pix_ready=1 -> 5 pixels, idx 0..4; strand0 fields match; frame_done with idx 4.
//   2 Hold pix_ready=0 across 2 pixels -> overflow=1 and pix_data = second pixel;
//     then pix_ready=1 -> one accept, pix_valid drops.
//   3 Issue r_clk after only 7 shifts -> bit_err one pulse; a following 24 good
//     words -> a correct pixel at the unchanged idx.
//   4 Stop sr_clk for IDLE_CYCLES mid-pixel (bit_pos=10), then resend a full
//     pixel -> emitted at idx 0 with the correct value.
//   5 Assert ar mid-pixel -> all outputs 0 immediately; the next full pixel
//     -> idx 0, no bit_err.
//   6 sr_clk and r_clk rise in the same sample on the 8th bit -> word accepted
//     including the 8th bit, no bit_err.

Source files
------------

// File: rtl/sr_frame_rx_pkg.sv
// Shared definitions for the LED shift-register receive path.
//   PIX_W        bits per GRB pixel
//   G_*/R_*/B_*  field offsets of the colour channels inside one pixel
//   clog2        constant-friendly ceil(log2(n)), returns 0 for n <= 1
package sr_frame_rx_pkg;

  localparam int PIX_W = 24;

  localparam int G_HI = 23;
  localparam int G_LO = 16;
  localparam int R_HI = 15;
  localparam int R_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sr_frame_rx_edge_sync.sv
// Input synchroniser plus registered rising-edge detector for one async line.
//   clk_in  system clock
//   ar      asynchronous active-low reset
//   din     raw asynchronous input
//   level   synchronised level, delayed so it lines up with rise
//   rise    one-cycle pulse per rising edge of the synchronised input
// Every instance has identical depth, so level outputs of different instances
// sampled in the same cycle refer to the same raw sampling instant.
module sr_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic ar,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_in or negedge ar) begin
    if (!ar) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign level = prev_q;

endmodule

// File: rtl/sr_frame_rx.sv
// Receive side of the LED shift-register link. Rebuilds latch words from the
// serial stream, assembles one 24-bit GRB pixel per strand and presents it on
// a valid/ready output.
//   clk_in      system clock (>= 4x sr_clk)
//   ar          asynchronous active-low reset
//   data_in     serial data (async)
//   sr_clk_in   serial shift clock (async, sampled)
//   r_clk_in    latch clock (async, sampled)
//   pix_data    STRANDS pixels; bits [24k+23:24k] belong to strand k, GRB
//   pix_idx     LED position of pix_data within the strand
//   pix_valid   pix_data/pix_idx valid
//   pix_ready   consumer ready
//   frame_done  pulse alongside the last pixel of a strand
//   bit_err     pulse when a latch arrives with the wrong number of shifts
//   overflow    sticky: a pending pixel was overwritten
// Handshake: a pixel transfers on a cycle where pix_valid & pix_ready are both
// high; until then pix_valid stays high and pix_data/pix_idx hold. A pixel that
// completes while the previous one is still pending replaces it.
module sr_frame_rx
  import sr_frame_rx_pkg::*;
#(
  parameter  int STRANDS      = 8,
  parameter  int BITS_PER_LED = PIX_W,
  parameter  int LEDS         = 5,
  parameter  int SYNC_STAGES  = 2,
  parameter  int IDLE_CYCLES  = 1024,
  localparam int IDX_W        = (LEDS > 1) ? clog2(LEDS) : 1
) (
  input  logic                            clk_in,
  input  logic                            ar,
  input  logic                            data_in,
  input  logic                            sr_clk_in,
  input  logic                            r_clk_in,
  output logic [STRANDS*BITS_PER_LED-1:0] pix_data,
  output logic [IDX_W-1:0]                pix_idx,
  output logic                            pix_valid,
  input  logic                            pix_ready,
  output logic                            frame_done,
  output logic                            bit_err,
  output logic                            overflow
);

  localparam int CNT_W = clog2(STRANDS + 2);
  localparam int BP_W  = clog2(BITS_PER_LED);
  localparam int IDL_W = clog2(IDLE_CYCLES + 1);

  logic data_s, sr_rise, r_rise;
  logic data_rise_unused, sr_level_unused, r_level_unused;

  sr_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk_in(clk_in), .ar(ar), .din(data_in), .level(data_s), .rise(data_rise_unused)
  );
  sr_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sr (
    .clk_in(clk_in), .ar(ar), .din(sr_clk_in), .level(sr_level_unused), .rise(sr_rise)
  );
  sr_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_r (
    .clk_in(clk_in), .ar(ar), .din(r_clk_in), .level(r_level_unused), .rise(r_rise)
  );

  logic [STRANDS-1:0]                   shreg, sh_nx;
  logic [CNT_W-1:0]                     sh_cnt, cnt_nx;
  logic [BP_W-1:0]                      bit_pos, tgt_bit;
  logic [IDX_W-1:0]                     led_cnt;
  logic [IDL_W-1:0]                     idle_cnt;
  logic [STRANDS-1:0][BITS_PER_LED-1:0] acc, acc_nx;
  logic                                 word_ok, word_bad, pix_done, idle_hit;

  // Shift is applied before the latch is judged, so a shift and a latch in the
  // same cycle behave as "shift, then latch".
  always_comb begin
    sh_nx  = shreg;
    cnt_nx = sh_cnt;
    if (sr_rise) begin
      sh_nx = {shreg[STRANDS-2:0], data_s};
      if (sh_cnt != CNT_W'(STRANDS + 1)) cnt_nx = sh_cnt + 1'b1;
    end
    word_ok  = r_rise && (cnt_nx == CNT_W'(STRANDS));
    word_bad = r_rise && !word_ok;
    // Pixels arrive MSB first: bit_pos 0 fills bit 23.
    tgt_bit  = BP_W'(BITS_PER_LED - 1) - bit_pos;
    acc_nx   = acc;
    if (word_ok) begin
      for (int k = 0; k < STRANDS; k++) acc_nx[k][tgt_bit] = sh_nx[k];
    end
    pix_done = word_ok && (bit_pos == BP_W'(BITS_PER_LED - 1));
    idle_hit = !sr_rise && (idle_cnt == IDL_W'(IDLE_CYCLES - 1));
  end

  always_ff @(posedge clk_in or negedge ar) begin
    if (!ar) begin
      shreg      <= '0;
      sh_cnt     <= '0;
      bit_pos    <= '0;
      led_cnt    <= '0;
      idle_cnt   <= '0;
      acc        <= '0;
      pix_data   <= '0;
      pix_idx    <= '0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      bit_err    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      bit_err    <= word_bad;
      shreg      <= sh_nx;
      sh_cnt     <= r_rise ? '0 : cnt_nx;
      idle_cnt   <= (sr_rise || idle_hit) ? '0 : idle_cnt + 1'b1;
      acc        <= acc_nx;

      if (word_bad) bit_pos <= '0;
      else if (word_ok) bit_pos <= pix_done ? '0 : bit_pos + 1'b1;

      if (pix_done) led_cnt <= (led_cnt == IDX_W'(LEDS - 1)) ? '0 : led_cnt + 1'b1;

      // A long gap in sr_clk marks a frame boundary; pending output is kept.
      if (idle_hit) begin
        bit_pos <= '0;
        led_cnt <= '0;
        sh_cnt  <= '0;
      end

      if (pix_done) begin
        if (pix_valid && !pix_ready) overflow <= 1'b1;
        pix_data   <= acc_nx;
        pix_idx    <= led_cnt;
        pix_valid  <= 1'b1;
        frame_done <= (led_cnt == IDX_W'(LEDS - 1));
      end else if (pix_valid && pix_ready) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sr_frame_rx.sv
module tb_sr_frame_rx;
  import sr_frame_rx_pkg::*;

  localparam int STRANDS = 8;
  localparam int LEDS    = 5;
  localparam int IDLE    = 1024;
  localparam int IDX_W   = 3;
  localparam int PW      = STRANDS * PIX_W;
  localparam int W       = IDX_W + PW;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic ar = 1'b0;
  logic data_in = 1'b0, sr_clk_in = 1'b0, r_clk_in = 1'b0, pix_ready = 1'b0;
  logic [PW-1:0]    pix_data;
  logic [IDX_W-1:0] pix_idx;
  logic             pix_valid, frame_done, bit_err, overflow;

  always #5 clk_in = ~clk_in;

  sr_frame_rx dut (
    .clk_in(clk_in), .ar(ar), .data_in(data_in), .sr_clk_in(sr_clk_in),
    .r_clk_in(r_clk_in), .pix_data(pix_data), .pix_idx(pix_idx),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_done(frame_done),
    .bit_err(bit_err), .overflow(overflow)
  );

  // ---------------- scoreboard state / reference model ----------------
  logic [W-1:0] exp_q[$];
  int pass_cnt = 0, check_cnt = 0;
  int err_seen = 0, frames_seen = 0;
  int exp_err = 0, exp_frames = 0, exp_led = 0;
  logic [PIX_W-1:0] cur_pix [STRANDS];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  function automatic logic [PW-1:0] pack_cur();
    logic [PW-1:0] p;
    for (int k = 0; k < STRANDS; k++) p[k*PIX_W +: PIX_W] = cur_pix[k];
    return p;
  endfunction

  task automatic randomize_cur();
    for (int k = 0; k < STRANDS; k++) cur_pix[k] = 24'($urandom());
  endtask

  // ---------------- driver tasks ----------------
  // Sends the top nbits of w, MSB first, so that after 8 shifts w[k] sits in
  // strand k's slot. 'same' raises r_clk together with the last sr_clk rise.
  task automatic send_word(input logic [7:0] w, input int nbits, input bit same);
    for (int i = 7; i >= 8 - nbits; i--) begin
      data_in   = w[i];
      sr_clk_in = 1'b0;
      tick(4);
      sr_clk_in = 1'b1;
      if (same && i == 8 - nbits) r_clk_in = 1'b1;
      tick(4);
    end
    sr_clk_in = 1'b0;
    if (same) begin
      r_clk_in = 1'b0;
    end else begin
      r_clk_in = 1'b1;
      tick(4);
      r_clk_in = 1'b0;
    end
  endtask

  // Sends cur_pix as 24 latch words and updates the reference model.
  task automatic send_pixel(input bit push, input bit same);
    logic [7:0] w;
    for (int b = 0; b < PIX_W; b++) begin
      for (int k = 0; k < STRANDS; k++) w[k] = cur_pix[k][PIX_W-1-b];
      send_word(w, 8, same);
    end
    if (push) exp_q.push_back({IDX_W'(exp_led), pack_cur()});
    if (exp_led == LEDS - 1) exp_frames++;
    exp_led = (exp_led + 1) % LEDS;
  endtask

  task automatic send_partial(input int nwords);
    for (int i = 0; i < nwords; i++) send_word(8'($urandom()), 8, 1'b0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      tick(1);
      t++;
    end
    check("drain_queue", exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_in) begin
    logic [W-1:0] e;
    if (ar) begin
      if (bit_err) err_seen++;
      if (frame_done) begin
        frames_seen++;
        check("frame_done_idx", pix_idx, LEDS - 1);
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check_cnt++;
          $display("FAIL unexpected_pixel: got idx %0d data %0h, expected none", pix_idx, pix_data);
        end else begin
          e = exp_q.pop_front();
          check("pixel_idx", pix_idx, e[W-1:PW]);
          check("pixel_data", pix_data, e[PW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [PIX_W-1:0] t1 [LEDS] = '{24'h00FF00, 24'hFF0000, 24'h0000FF, 24'h00FF00, 24'hFFFFFF};
  logic [PW-1:0] b_data;

  initial begin
    tick(3);
    check("reset_flags", {pix_valid, frame_done, bit_err, overflow, pix_idx}, 0);
    check("reset_data", pix_data, 0);
    ar = 1'b1;
    pix_ready = 1'b1;
    tick(4);

    // 1: fixed strand-0 frame, then a fully random frame
    for (int k = 0; k < STRANDS; k++) cur_pix[k] = '0;
    for (int p = 0; p < LEDS; p++) begin
      cur_pix[0] = t1[p];
      send_pixel(1'b1, 1'b0);
    end
    drain();
    for (int p = 0; p < LEDS; p++) begin
      randomize_cur();
      send_pixel(1'b1, 1'b0);
    end
    drain();
    tick(4);
    check("frame_count_t1", frames_seen, exp_frames);

    // 2: two pixels while the consumer stalls
    pix_ready = 1'b0;
    randomize_cur();
    send_pixel(1'b0, 1'b0);
    randomize_cur();
    b_data = pack_cur();
    send_pixel(1'b1, 1'b0);
    tick(10);
    check("overflow_set", overflow, 1);
    check("valid_held", pix_valid, 1);
    check("overwritten_data", pix_data, b_data);
    pix_ready = 1'b1;
    drain();
    tick(3);
    check("valid_dropped", pix_valid, 0);

    // 3: short word, then a clean pixel at the same LED index
    send_partial(5);
    send_word(8'($urandom()), 7, 1'b0);
    tick(10);
    exp_err++;
    check("bit_err_short", err_seen, exp_err);
    randomize_cur();
    send_pixel(1'b1, 1'b0);
    drain();

    // 4: idle gap mid-pixel resynchronises the frame
    send_partial(10);
    tick(IDLE + 50);
    exp_led = 0;
    randomize_cur();
    send_pixel(1'b1, 1'b0);
    drain();
    check("bit_err_idle", err_seen, exp_err);

    // 5: asynchronous reset mid-pixel
    send_partial(10);
    #3;
    ar = 1'b0;
    #1;
    check("async_reset_flags", {pix_valid, frame_done, bit_err, overflow, pix_idx}, 0);
    check("async_reset_data", pix_data, 0);
    tick(2);
    ar = 1'b1;
    exp_led = 0;
    tick(2);
    randomize_cur();
    send_pixel(1'b1, 1'b0);
    drain();
    check("bit_err_after_reset", err_seen, exp_err);

    // 6: shift and latch on the same sample
    randomize_cur();
    send_pixel(1'b1, 1'b1);
    drain();
    tick(4);
    check("bit_err_same_edge", err_seen, exp_err);
    check("frame_count_end", frames_seen, exp_frames);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
